// File: rtl/cnn_pkg.sv
// cnn_pkg: types and defaults shared by the CNN datapath blocks.
//   bank_state_t : life cycle of one activation bank (EMPTY/FILLING/FULL/BUSY)
//   rdfsm_t      : read/launch FSM of the feature buffer (IDLE/LAUNCH/BUSY)
//   DEF_DATA_WIDTH, DEF_IN_DIM : defaults shared with the dense layer
//   addr_width() : max(1, clog2(n)), used for address widths
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IN_DIM     = 1568;

  // Enumerators carry a prefix because both types have a BUSY state.
  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_BUSY
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LAUNCH,
    RD_BUSY
  } rdfsm_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_buffer_if.sv
// feature_buffer_if: upstream sample stream plus dense-layer launch/read bus.
//   s_valid/s_ready/s_data/s_last : flattened activation stream
//   start/done                    : frame launch and release handshake
//   rd_en/rd_addr/rd_q            : synchronous sample reads by the dense layer
// Modports: master = upstream stage + dense layer side, slave = feature_buffer.
interface feature_buffer_if import cnn_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IN_DIM     = DEF_IN_DIM
);
  localparam int AW = addr_width(IN_DIM);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  start;
  logic                  done;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_q;

  modport master (
    output s_valid, s_data, s_last, done, rd_en, rd_addr,
    input  s_ready, start, rd_q
  );

  modport slave (
    input  s_valid, s_data, s_last, done, rd_en, rd_addr,
    output s_ready, start, rd_q
  );

endinterface

// File: rtl/feature_bank_ram.sv
// feature_bank_ram: simple dual-port memory holding both activation banks.
//   Physical address = bank * IN_DIM + index (computed by the caller).
//   we/waddr/wdata : synchronous write port
//   re/raddr/q     : registered read port; q holds while re is 0
// The array itself is never reset; only the output register is.
module feature_bank_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/feature_buffer.sv
// feature_buffer: double-buffered activation store between flatten/pool and
// the dense layer. Frames of IN_DIM samples fill one bank while the other is
// read; a full bank is launched with a one-cycle start pulse and released by
// the dense layer's done pulse.
//   clk, reset (async, active-low)
//   bus        : feature_buffer_if slave (stream in, start/done, reads)
//   frame_err  : sticky framing error (0 unless FEATBUF_LAST_CHECK_EN)
//   banks_full : number of banks holding a FULL or BUSY frame
// Optional macro FEATBUF_LAST_CHECK_EN: check s_last against the sample
// count; an early s_last discards the frame, a missing one only flags it.
module feature_buffer import cnn_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IN_DIM     = DEF_IN_DIM
) (
  input  logic              clk,
  input  logic              reset,
  feature_buffer_if.slave   bus,
  output logic              frame_err,
  output logic [1:0]        banks_full
);

  localparam int AW  = addr_width(IN_DIM);
  localparam int PAW = addr_width(2 * IN_DIM);
  localparam logic [AW-1:0]  LAST_IDX = AW'(IN_DIM - 1);
  localparam logic [PAW-1:0] BANK_OFS = PAW'(IN_DIM);

  logic          wr_bank_reg, wr_bank_next;
  logic [AW-1:0] wr_idx_reg, wr_idx_next;
  logic          rd_bank_reg, rd_bank_next;
  rdfsm_t        rd_state_reg, rd_state_next;
  logic          frame_err_reg, frame_err_next;

  logic       accept, at_end, commit, discard, launch, release_bank;
  logic [1:0] bank_open, bank_full, bank_held;

  assign bus.s_ready = bank_open[wr_bank_reg];
  assign accept      = bus.s_valid & bus.s_ready;
  assign at_end      = (wr_idx_reg == LAST_IDX);
  assign commit      = accept & at_end;

`ifdef FEATBUF_LAST_CHECK_EN
  assign discard        = accept & bus.s_last & ~at_end;
  assign frame_err_next = frame_err_reg | discard | (commit & ~bus.s_last);
`else
  logic unused_last;
  assign unused_last    = bus.s_last;
  assign discard        = 1'b0;
  assign frame_err_next = 1'b0;
`endif

  assign frame_err  = frame_err_reg;
  assign banks_full = {1'b0, bank_held[0]} + {1'b0, bank_held[1]};

  // Write pointer: advance per accepted sample, wrap and switch bank at frame end.
  always_comb begin
    wr_idx_next  = wr_idx_reg;
    wr_bank_next = wr_bank_reg;
    if (commit) begin
      wr_idx_next  = '0;
      wr_bank_next = ~wr_bank_reg;
    end else if (discard) begin
      wr_idx_next  = '0;
    end else if (accept) begin
      wr_idx_next  = wr_idx_reg + AW'(1);
    end
  end

  // Read FSM outputs and next state.
  always_comb begin
    rd_state_next = rd_state_reg;
    rd_bank_next  = rd_bank_reg;
    bus.start     = 1'b0;
    launch        = 1'b0;
    release_bank  = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        if (bank_full[rd_bank_reg]) rd_state_next = RD_LAUNCH;
      end
      RD_LAUNCH: begin
        bus.start     = 1'b1;
        launch        = 1'b1;
        rd_state_next = RD_BUSY;
      end
      RD_BUSY: begin
        if (bus.done) begin
          release_bank  = 1'b1;
          rd_bank_next  = ~rd_bank_reg;
          rd_state_next = RD_IDLE;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Per-bank state. Write events only touch an EMPTY/FILLING bank and read
  // events only a FULL/BUSY one, so both may land in the same cycle safely.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    bank_state_t st_reg, st_next;

    always_comb begin
      st_next = st_reg;
      if (wr_bank_reg == 1'(gi)) begin
        if (commit)       st_next = BANK_FULL;
        else if (discard) st_next = BANK_EMPTY;
        else if (accept)  st_next = BANK_FILLING;
      end
      if (rd_bank_reg == 1'(gi)) begin
        if (launch)            st_next = BANK_BUSY;
        else if (release_bank) st_next = BANK_EMPTY;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) st_reg <= BANK_EMPTY;
      else        st_reg <= st_next;
    end

    assign bank_open[gi] = (st_reg == BANK_EMPTY) || (st_reg == BANK_FILLING);
    assign bank_full[gi] = (st_reg == BANK_FULL);
    assign bank_held[gi] = (st_reg == BANK_FULL) || (st_reg == BANK_BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_reg   <= 1'b0;
      wr_idx_reg    <= '0;
      rd_bank_reg   <= 1'b0;
      rd_state_reg  <= RD_IDLE;
      frame_err_reg <= 1'b0;
    end else begin
      wr_bank_reg   <= wr_bank_next;
      wr_idx_reg    <= wr_idx_next;
      rd_bank_reg   <= rd_bank_next;
      rd_state_reg  <= rd_state_next;
      frame_err_reg <= frame_err_next;
    end
  end

  logic [PAW-1:0] waddr, raddr;
  assign waddr = (wr_bank_reg ? BANK_OFS : '0) + PAW'(wr_idx_reg);
  assign raddr = (rd_bank_reg ? BANK_OFS : '0) + PAW'(bus.rd_addr);

  feature_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (2 * IN_DIM),
    .AW         (PAW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (waddr),
    .wdata (bus.s_data),
    .re    (bus.rd_en && (rd_state_reg == RD_BUSY)),
    .raddr (raddr),
    .q     (bus.rd_q)
  );

endmodule

// File: tb/tb_feature_buffer.sv
// tb_feature_buffer: self-checking bench for feature_buffer with IN_DIM=8.
// Expected read data is queued when frames are driven and popped as the
// dense-side reads return data.
module tb_feature_buffer;

  localparam int DW = 16;
  localparam int N  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_err;
  logic [1:0] banks_full;

  feature_buffer_if #(.DATA_WIDTH(DW), .IN_DIM(N)) bus();

  feature_buffer #(.DATA_WIDTH(DW), .IN_DIM(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .frame_err  (frame_err),
    .banks_full (banks_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int start_cnt = 0;
  int start_cyc = -1;
  always @(negedge clk) begin
    if (bus.start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] sb[$];
  int last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic last);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("s_ready_wait", 32'(bus.s_ready), 1);
    @(posedge clk); #1;
    last_acc    = cyc;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input logic last_on, input logic record);
    for (int i = 0; i < N; i++) begin
      if (record) sb.push_back(DW'(base + i));
      push(DW'(base + i), last_on && (i == N - 1));
    end
    $display("frame base=%0d accepted at cycle %0d", base, last_acc);
  endtask

  task automatic read_frame();
    logic [DW-1:0] exp;
    for (int a = 0; a < N; a++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 3'(a);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 1);
      end else begin
        exp = sb.pop_front();
        chk($sformatf("rd_q[%0d]", a), 32'(bus.rd_q), 32'(exp));
        $display("rd addr=%0d q=%0d exp=%0d", a, bus.rd_q, exp);
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_start(input int prev);
    int t;
    t = 0;
    while (start_cnt <= prev && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("start_wait", 32'(start_cnt), 32'(prev + 1));
  endtask

  task automatic pulse_done(output int d_edge);
    bus.done = 1'b1;
    @(posedge clk); #1;
    d_edge   = cyc;
    bus.done = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    bus.done = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_s_ready", 32'(bus.s_ready), 1);
    chk("rst_start", 32'(bus.start), 0);
    chk("rst_rd_q", 32'(bus.rd_q), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_banks_full", 32'(banks_full), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single frame, start latency, reads
    base = start_cnt;
    send_frame(1, 1'b1, 1'b1);
    wait_start(base);
    chk("t1_start_lat", 32'(start_cyc), 32'(last_acc + 1));
    repeat (2) @(posedge clk); #1;
    chk("t1_one_start", 32'(start_cnt), 32'(base + 1));
    chk("t1_banks_full", 32'(banks_full), 1);
    read_frame();
    @(posedge clk); #1;
    chk("t1_rd_q_hold", 32'(bus.rd_q), 8);
    pulse_done(d);
    chk("t1_banks_after_done", 32'(banks_full), 0);

    // Two frames, done withheld, third frame stalls
    base = start_cnt;
    send_frame(1, 1'b1, 1'b1);
    send_frame(11, 1'b1, 1'b1);
    bus.s_valid = 1'b1; bus.s_data = 16'd41;
    repeat (3) @(posedge clk); #1;
    chk("t2_banks_full", 32'(banks_full), 2);
    chk("t2_s_ready_stall", 32'(bus.s_ready), 0);
    chk("t2_one_start", 32'(start_cnt), 32'(base + 1));
    bus.s_valid = 1'b0;
    read_frame();
    pulse_done(d);
    chk("t2_s_ready_freed", 32'(bus.s_ready), 1);
    wait_start(base + 1);
    chk("t2_start_after_done", 32'(start_cyc), 32'(d + 1));
    send_frame(41, 1'b1, 1'b1);
    read_frame();
    base = start_cnt;
    pulse_done(d);
    wait_start(base);
    chk("t2_third_start", 32'(start_cyc), 32'(d + 1));
    read_frame();
    pulse_done(d);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) push(DW'(91 + i), 1'b0);
    reset = 1'b0;
    #1;
    chk("t3_s_ready", 32'(bus.s_ready), 1);
    chk("t3_start", 32'(bus.start), 0);
    chk("t3_rd_q", 32'(bus.rd_q), 0);
    chk("t3_frame_err", 32'(frame_err), 0);
    chk("t3_banks_full", 32'(banks_full), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    base = start_cnt;
    repeat (3) @(posedge clk); #1;
    chk("t3_no_stale_start", 32'(start_cnt), 32'(base));
    send_frame(21, 1'b1, 1'b1);
    wait_start(base);
    chk("t3_start_lat", 32'(start_cyc), 32'(last_acc + 1));
    read_frame();
    pulse_done(d);

    // done coincides with completion of the other bank
    base = start_cnt;
    send_frame(51, 1'b1, 1'b1);
    wait_start(base);
    read_frame();
    for (int i = 0; i < N - 1; i++) begin
      sb.push_back(DW'(61 + i));
      push(DW'(61 + i), 1'b0);
    end
    base = start_cnt;
    chk("t4_s_ready_pre", 32'(bus.s_ready), 1);
    sb.push_back(16'd68);
    bus.s_valid = 1'b1; bus.s_data = 16'd68; bus.s_last = 1'b1; bus.done = 1'b1;
    @(posedge clk); #1;
    d = cyc;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.done = 1'b0;
    chk("t4_s_ready_d1", 32'(bus.s_ready), 1);
    chk("t4_banks_full", 32'(banks_full), 1);
    send_frame(71, 1'b1, 1'b1);
    chk("t4_frame_done", 32'(last_acc), 32'(d + N));
    wait_start(base);
    chk("t4_start_d2", 32'(start_cyc), 32'(d + 1));
    read_frame();
    base = start_cnt;
    pulse_done(d);
    wait_start(base);
    read_frame();
    pulse_done(d);

`ifdef FEATBUF_LAST_CHECK_EN
    // Early s_last discards the frame
    base = start_cnt;
    for (int i = 0; i < 4; i++) push(DW'(81 + i), i == 3);
    repeat (4) @(posedge clk); #1;
    chk("t5_frame_err", 32'(frame_err), 1);
    chk("t5_no_start", 32'(start_cnt), 32'(base));
    chk("t5_banks_full", 32'(banks_full), 0);
    send_frame(31, 1'b1, 1'b1);
    wait_start(base);
    chk("t5_start_lat", 32'(start_cyc), 32'(last_acc + 1));
    read_frame();
    pulse_done(d);
    chk("t5_err_sticky", 32'(frame_err), 1);
`else
    // s_last ignored: framing purely by count
    base = start_cnt;
    send_frame(101, 1'b0, 1'b1);
    wait_start(base);
    chk("t5_start_lat", 32'(start_cyc), 32'(last_acc + 1));
    chk("t5_frame_err", 32'(frame_err), 0);
    read_frame();
    pulse_done(d);
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/feature_buffer.md
# feature_buffer

Double-buffered activation store sitting between the flatten/pool stage and the dense layer. Accepts a valid/ready stream of flattened Q-format activations, packs each frame of IN_DIM samples into one of two BRAM banks, then launches the dense layer with a one-cycle `start` pulse. It serves the dense layer's sequential input reads with one-cycle synchronous latency, and releases the bank on its `done` pulse. While one bank is read, the next frame fills the other, so the upstream stage stalls only when both banks are occupied.

## Interface
- DATA_WIDTH, 16, activation width (signed Q-format, passed through untouched)
- IN_DIM, 1568, samples per frame; equals the dense layer's input length
- AW, derived = max(1, $clog2(IN_DIM)), read-address width
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low (buffer resets while 0)
- s_valid  input  1  upstream sample valid
- s_ready  output  1  buffer can accept a sample this cycle
- s_data  input  DATA_WIDTH  signed activation
- s_last  input  1  marks final sample of a frame
- start  output  1  one-cycle pulse: a full frame is ready for the dense layer
- done  input  1  one-cycle pulse from the dense layer: frame consumed
- rd_en  input  1  read enable (dense in_en)
- rd_addr  input  AW  sample index 0..IN_DIM-1 (dense in_addr)
- rd_q  output  DATA_WIDTH  read data, valid the cycle after rd_en
- frame_err  output  1  sticky framing error
- banks_full  output  2  count of banks holding a FULL or BUSY frame

## Operation
- Each bank has a state: EMPTY, FILLING, FULL or BUSY. The write pointer is `wr_bank` with index `wr_idx`; the read pointer is `rd_bank`.
- `s_ready` is 1 iff bank[wr_bank] is EMPTY or FILLING. It is derived combinationally from registered state only; it never depends on `s_valid`.
- Handshake: `s_valid & s_ready` writes `s_data` to bank[wr_bank][wr_idx].
  - The first accepted sample moves the bank EMPTY→FILLING.
  - On `wr_idx == IN_DIM-1`: bank→FULL, `wr_idx`→0, `wr_bank` toggles.
  - Otherwise `wr_idx` increments.
- Read FSM has states IDLE, LAUNCH, BUSY:
  - IDLE→LAUNCH when bank[rd_bank] is FULL.
  - LAUNCH: `start`=1 for exactly one cycle, bank→BUSY, then go to BUSY.
  - BUSY: `rd_en` reads bank[rd_bank][rd_addr]. On `done`: bank→EMPTY, `rd_bank` toggles, go to IDLE.
- `rd_en` in IDLE or LAUNCH is ignored. `rd_q` holds its last value whenever `rd_en` is 0.
- `rd_addr` ≥ IN_DIM is undefined data, but must never corrupt state.
- `done` outside BUSY is ignored.
- Banks are only ever served in fill order.

## Timing
- Reset values: `s_ready` 1 (both banks EMPTY), `start` 0, `rd_q` 0, `frame_err` 0, `banks_full` 0. Read FSM is IDLE, both pointers 0.
- Reset asserted mid-frame or mid-read:
  - Everything returns to the reset values; any partial frame is discarded.
  - Memory contents are not cleared, and no stale frame is ever launched.
- Start latency: final sample accepted in cycle N gives bank FULL in N+1 and `start` high in N+2, provided the read FSM is IDLE.
- Read latency: `rd_en` in cycle K gives `rd_q` valid in K+1. Back-to-back `rd_en` is supported at full rate.
- After `done` in cycle D, the next `start` is no earlier than D+2.
- `done` and a frame completion in the same cycle: both updates apply. A bank freed by `done` is visible on `s_ready` in D+1.
- Both banks FULL/BUSY: `s_ready`=0 until the `done` release.

## Configuration
- Macro `FEATBUF_LAST_CHECK_EN`, when defined:
  - `s_last` asserted with `wr_idx` < IN_DIM-1 sets `frame_err`, discards the bank (→EMPTY, `wr_idx`→0) and launches nothing.
  - A sample at `wr_idx == IN_DIM-1` without `s_last` sets `frame_err`, but the bank is still committed FULL.
  - `frame_err` clears only on reset.
- Macro undefined: `s_last` is ignored, framing is purely by count, and `frame_err` is tied to 0.

## Structure
- Shared package `cnn_pkg` holds:
  - `bank_state_t` (EMPTY/FILLING/FULL/BUSY) and `rdfsm_t` (IDLE/LAUNCH/BUSY);
  - the default DATA_WIDTH and IN_DIM constants, shared with the dense layer.
- One sub-module, `feature_bank_ram`, with these properties:
  - simple dual-port memory of depth 2·IN_DIM, physical address = bank·IN_DIM + index;
  - synchronous write port and synchronous registered read port;
  - block-RAM style, no reset on the array.

## Test plan
- IN_DIM=8, stream 1..8 with `s_last` on the 8th -> `start` pulses once in N+2; `rd_en` at addresses 0..7 returns 1..8, each one cycle later.
- Two frames back-to-back (1..8, then 11..18) with `done` withheld -> `banks_full`=2 and `s_ready`=0 for a third frame. Then:
  - `done` -> `start` pulses again two cycles later;
  - reads return 11..18;
  - the third frame is accepted.
- Reset asserted after 5 samples -> outputs at reset values; a fresh frame 21..28 launches, and reads return 21..28 with no stale data.
- With `FEATBUF_LAST_CHECK_EN`, `s_last` on the 4th sample -> `frame_err`=1 and no `start`; the next correct frame 31..38 launches normally.
- `done` for bank0 in the same cycle bank1 completes -> `start` for bank1 in D+2, and bank0 accepts data from D+1.
- Without the macro, 8 samples with `s_last` never asserted -> `start` pulses and `frame_err` stays 0.
